maxpool_scheduler: RTL and testbench
====================================

# maxpool_scheduler

Sequencer for 2x2 / stride-2 max pooling over a feature map held in a single-port, 1-cycle-latency read memory (the convolution output buffer). It walks the map window by window, fetches the four pixels of each window serially, keeps a running signed maximum, and streams one pooled value per window to the next layer over a valid/ready handshake. One shared compare replaces the fully parallel comparator array, so the block suits area-constrained layers.

## Interface
- `DATA_WIDTH`, 16: pixel width, signed two's complement fixed point.
- `InputH`, 28: input rows per channel.
- `InputW`, 28: input columns per channel.
- `Depth`, 1: channel count.
- `AW`, derived: `$clog2(InputH*InputW*Depth)`, read address width.
- `OW`, derived: `$clog2(Depth*(InputH/2)*(InputW/2))`, output index width.

- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to pool the whole map; ignored while `busy`.
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the final output handshake.
- `rd_en`  out  1  memory read strobe.
- `rd_addr`  out  AW  read address = d*InputH*InputW + r*InputW + c.
- `rd_data`  in  DATA_WIDTH  read data, valid exactly one cycle after `rd_en`.
- `out_valid`  out  1  pooled value available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_WIDTH  pooled maximum.
- `out_idx`  out  OW  output index = d*(InputH/2)*(InputW/2) + (r/2)*(InputW/2) + c/2.

## Operation
- FSM states: IDLE, FETCH, DRAIN, OUT, DONE.
- IDLE: `start`=1 → FETCH; window counters d=0, wr=0, wc=0, k=0.
- FETCH: four cycles, k=0..3. `rd_en`=1 with addresses in the order (r,c), (r,c+1), (r+1,c), (r+1,c+1), where r=2*wr and c=2*wc. After k=3 → DRAIN.
- Running max: a registered `rd_en_q` qualifies `rd_data`. The first beat of a window loads max; later beats do max <= (rd_data > max, signed) ? rd_data : max. Ties keep the earlier value.
- DRAIN: one cycle that captures the fourth beat, then → OUT.
- OUT: `out_valid`=1. `out_data` and `out_idx` stay stable until `out_ready`.
  - On handshake the counters advance, wc first, then wr, then d.
  - If the window just accepted was the last, → DONE; otherwise → FETCH.
- DONE: `done`=1 for one cycle, then → IDLE.
- Odd InputH or InputW: the last row or column is skipped (floor division). Windows never read past the map.
- `start` outside IDLE has no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, FSM=IDLE.
- Reset mid-operation aborts immediately. No further `rd_en` or `out_valid` is issued, and no `done` follows.
- With `start` in cycle 0:
  - `rd_en` is high in cycles 1–4.
  - `rd_data` is sampled in cycles 2–5.
  - DRAIN is cycle 5.
  - `out_valid` rises in cycle 6.
- A handshake in cycle t puts the next window's first `rd_en` in cycle t+1. With `out_ready` held at 1, a window completes every 6 cycles.
- Total latency is 6*N + 1 cycles from `start` to `done`, where N = Depth*(InputH/2)*(InputW/2) and `out_ready` is held at 1.
- `busy` falls in the cycle after `done`.
- `out_ready` is ignored when `out_valid`=0. No combinational path runs from `out_ready` or `rd_data` to any output.

## Structure
- Package `maxpool_pkg`: the FSM state enum `mp_state_t`, and a function `mp_addr_w(h,w,d)` returning the clog2 address width.
- Sub-module `maxpool_addr_gen` holds the d/wr/wc/k counters, computes `rd_addr` and `out_idx`, and flags the last window. The top level keeps the FSM, the max register and the handshake.

## Test plan
- 4x4x1 map holding values 0..15 row-major, `out_ready`=1 → outputs 5, 7, 13, 15 at idx 0–3; `done` 25 cycles after `start`.
- Window {-3, -7, -1, -2} (0xFFFD, 0xFFF9, 0xFFFF, 0xFFFE) → `out_data`=0xFFFF (-1), which checks the signed compare.
- `out_ready` held 0 for 10 cycles in OUT → `out_valid` stays 1, `out_data`/`out_idx` stay constant, and no `rd_en` is issued.
- 5x6x2 map → 6 outputs per channel, 12 in total. Addresses never touch row 4 of either channel, and channel 1 addresses start at 30.
- `rst_n` low during FETCH of window 2 → all outputs 0 at once, with no `done`. A fresh `start` then restarts from idx 0.
- `start` pulsed while `busy` → no change to the sequence or to the `done` timing.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and width helpers for the 2x2 / stride-2 max-pool sequencer.
package maxpool_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StOut,
    StDone
  } mp_state_t;

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned mp_clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

  // Read address width for an h x w x d feature map.
  function automatic int unsigned mp_addr_w(input int unsigned h, input int unsigned w,
                                            input int unsigned d);
    return mp_clog2_min1(h * w * d);
  endfunction

  // Output index width: one pooled value per 2x2 window, odd edges dropped.
  function automatic int unsigned mp_idx_w(input int unsigned h, input int unsigned w,
                                           input int unsigned d);
    return mp_clog2_min1(d * (h / 2) * (w / 2));
  endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Window walker: channel / window-row / window-col / beat counters, the read
// address of the current beat, the pooled output index and last-window flag.
module maxpool_addr_gen
  import maxpool_pkg::*;
#(
  parameter int unsigned InputH = 28,
  parameter int unsigned InputW = 28,
  parameter int unsigned Depth  = 1,
  parameter int unsigned AW     = mp_addr_w(InputH, InputW, Depth),
  parameter int unsigned OW     = mp_idx_w(InputH, InputW, Depth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_step,
  input  logic          i_advance,
  output logic [AW-1:0] o_rd_addr,
  output logic [OW-1:0] o_out_idx,
  output logic          o_first_beat,
  output logic          o_last_beat,
  output logic          o_last_win
);

  // Floor division drops a trailing odd row / column.
  localparam int unsigned WinH = InputH / 2;
  localparam int unsigned WinW = InputW / 2;
  localparam int unsigned DW   = mp_clog2_min1(Depth);
  localparam int unsigned RW   = mp_clog2_min1(WinH);
  localparam int unsigned CW   = mp_clog2_min1(WinW);

  logic [DW-1:0] r_d;
  logic [RW-1:0] r_wr;
  logic [CW-1:0] r_wc;
  logic [1:0]    r_k;

  logic          w_last_d;
  logic          w_last_wr;
  logic          w_last_wc;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;

  assign w_last_d  = (r_d == DW'(Depth - 1));
  assign w_last_wr = (r_wr == RW'(WinH - 1));
  assign w_last_wc = (r_wc == CW'(WinW - 1));

  // Beat order inside a window: (r,c), (r,c+1), (r+1,c), (r+1,c+1).
  assign w_row = AW'({r_wr, 1'b0}) + AW'(r_k[1]);
  assign w_col = AW'({r_wc, 1'b0}) + AW'(r_k[0]);

  assign o_rd_addr    = AW'(r_d) * AW'(InputH * InputW) + w_row * AW'(InputW) + w_col;
  assign o_out_idx    = OW'(r_d) * OW'(WinH * WinW) + OW'(r_wr) * OW'(WinW) + OW'(r_wc);
  assign o_first_beat = (r_k == 2'd0);
  assign o_last_beat  = (r_k == 2'd3);
  assign o_last_win   = w_last_d && w_last_wr && w_last_wc;

  // Beat counter steps per read; window counters roll wc, then wr, then d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d  <= '0;
      r_wr <= '0;
      r_wc <= '0;
      r_k  <= '0;
    end else if (i_clear) begin
      r_d  <= '0;
      r_wr <= '0;
      r_wc <= '0;
      r_k  <= '0;
    end else begin
      if (i_step) begin
        r_k <= r_k + 2'd1;  // wraps to 0 after the fourth beat
      end
      if (i_advance) begin
        if (w_last_wc) begin
          r_wc <= '0;
          if (w_last_wr) begin
            r_wr <= '0;
            r_d  <= w_last_d ? '0 : r_d + DW'(1);
          end else begin
            r_wr <= r_wr + RW'(1);
          end
        end else begin
          r_wc <= r_wc + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_scheduler.sv
// 2x2 / stride-2 max-pool sequencer: serial fetch of four pixels per window
// through one signed comparator, one pooled value per window on valid/ready.
module maxpool_scheduler
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned InputH     = 28,
  parameter int unsigned InputW     = 28,
  parameter int unsigned Depth      = 1,
  parameter int unsigned AW         = mp_addr_w(InputH, InputW, Depth),
  parameter int unsigned OW         = mp_idx_w(InputH, InputW, Depth)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OW-1:0]         out_idx
);

  mp_state_t r_state;
  logic      r_busy;
  logic      r_done;
  logic      r_rd_en;
  logic      r_out_valid;
  logic      r_rd_en_q;
  logic      r_first_q;

  logic signed [DATA_WIDTH-1:0] r_max;

  logic w_clear;
  logic w_advance;
  logic w_first_beat;
  logic w_last_beat;
  logic w_last_win;

  assign w_clear   = (r_state == StIdle) && start;
  assign w_advance = (r_state == StOut) && out_ready;

  maxpool_addr_gen #(
    .InputH (InputH),
    .InputW (InputW),
    .Depth  (Depth),
    .AW     (AW),
    .OW     (OW)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_step       (r_rd_en),
    .i_advance    (w_advance),
    .o_rd_addr    (rd_addr),
    .o_out_idx    (out_idx),
    .o_first_beat (w_first_beat),
    .o_last_beat  (w_last_beat),
    .o_last_win   (w_last_win)
  );

  // Control FSM; every control output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StFetch;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
          end
        end
        StFetch: begin
          if (w_last_beat) begin
            r_state <= StDrain;
            r_rd_en <= 1'b0;
          end
        end
        StDrain: begin
          // Fourth beat lands in the max register this cycle.
          r_state     <= StOut;
          r_out_valid <= 1'b1;
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_win) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StFetch;
              r_rd_en <= 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= StIdle;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Running signed max; strict compare so ties keep the earlier pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en_q <= 1'b0;
      r_first_q <= 1'b0;
      r_max     <= '0;
    end else begin
      r_rd_en_q <= r_rd_en;
      r_first_q <= r_rd_en && w_first_beat;
      if (r_rd_en_q && (r_first_q || ($signed(rd_data) > r_max))) begin
        r_max <= $signed(rd_data);
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_max;

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Directed bench: a 4x4x1 instance driven from a window table plus
// hand-written backpressure / reset / start-while-busy sequences, and a
// 5x6x2 instance checked against a small pooling model.
module tb_maxpool_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: 4x4x1 ----------------
  logic        a_start = 1'b0, a_busy, a_done, a_rd_en, a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [3:0]  a_rd_addr;
  logic [15:0] a_rd_data = '0, a_out_data;
  logic [1:0]  a_out_idx;
  logic [15:0] mem_a [16];

  maxpool_scheduler #(
    .DATA_WIDTH (16),
    .InputH     (4),
    .InputW     (4),
    .Depth      (1)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (a_start),
    .busy      (a_busy),
    .done      (a_done),
    .rd_en     (a_rd_en),
    .rd_addr   (a_rd_addr),
    .rd_data   (a_rd_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_idx   (a_out_idx)
  );

  // ---------------- instance B: 5x6x2 ----------------
  logic        b_start = 1'b0, b_busy, b_done, b_rd_en, b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [5:0]  b_rd_addr;
  logic [15:0] b_rd_data = '0, b_out_data;
  logic [3:0]  b_out_idx;
  logic [15:0] mem_b [64];

  maxpool_scheduler #(
    .DATA_WIDTH (16),
    .InputH     (5),
    .InputW     (6),
    .Depth      (2)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (b_start),
    .busy      (b_busy),
    .done      (b_done),
    .rd_en     (b_rd_en),
    .rd_addr   (b_rd_addr),
    .rd_data   (b_rd_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_idx   (b_out_idx)
  );

  // 1-cycle-latency memories.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  // Monitors.
  logic [15:0] qa_data[$];
  logic [1:0]  qa_idx[$];
  logic [15:0] qb_data[$];
  logic [3:0]  qb_idx[$];
  logic [5:0]  qb_addr[$];
  int a_done_cnt = 0, a_rd_cnt = 0, b_done_cnt = 0;
  int unsigned a_done_cyc = 0, b_done_cyc = 0;
  logic a_prev_done = 1'b0, a_busy_at_done = 1'b0, a_busy_after_done = 1'b1;

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      qa_data.push_back(a_out_data);
      qa_idx.push_back(a_out_idx);
    end
    if (a_rd_en) a_rd_cnt++;
    if (a_prev_done) a_busy_after_done = a_busy;
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc = cyc;
      a_busy_at_done = a_busy;
    end
    a_prev_done = a_done;
    if (b_out_valid && b_out_ready) begin
      qb_data.push_back(b_out_data);
      qb_idx.push_back(b_out_idx);
    end
    if (b_rd_en) qb_addr.push_back(b_rd_addr);
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
  end

  // Window table: pixels in fetch order and the expected pooled max.
  typedef struct packed {
    logic [15:0] p0, p1, p2, p3, exp;
  } vec_t;
  vec_t vecs [8];

  task automatic load_a(input int base);
    for (int w = 0; w < 4; w++) begin
      int a0;
      a0 = (2 * (w / 2)) * 4 + 2 * (w % 2);
      mem_a[a0]     = vecs[base + w].p0;
      mem_a[a0 + 1] = vecs[base + w].p1;
      mem_a[a0 + 4] = vecs[base + w].p2;
      mem_a[a0 + 5] = vecs[base + w].p3;
    end
  endtask

  task automatic compare_a(input int base);
    chk("a_n_out", qa_data.size(), 4);
    for (int w = 0; w < 4; w++) begin
      if (w < qa_data.size()) begin
        chk($sformatf("a_rec%0d_data", base + w), qa_data[w], vecs[base + w].exp);
        chk($sformatf("a_rec%0d_idx", base + w), qa_idx[w], w);
      end
    end
  endtask

  // Full run on A with out_ready=1; optional start pulses while busy.
  task automatic run_a(input int base, input bit glitch);
    int d0;
    int unsigned s_cyc;
    load_a(base);
    qa_data.delete();
    qa_idx.delete();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    d0 = a_done_cnt;
    a_rd_cnt = 0;
    a_start = 1'b1;
    s_cyc = cyc;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (a_done_cnt != d0) break;
      a_start = glitch && (c == 3 || c == 6 || c == 9 || c == 25);
    end
    a_start = 1'b0;
    chk("a_done_pulse", a_done_cnt - d0, 1);
    chk("a_latency", a_done_cyc - s_cyc, 25);
    chk("a_busy_at_done", a_busy_at_done, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("a_busy_after_done", a_busy_after_done, 0);
    chk("a_rd_count", a_rd_cnt, 16);
    compare_a(base);
  endtask

  function automatic logic [15:0] b_val(input int a);
    if (((a % 30) / 6) == 4) return 16'h7FFF;  // skipped row: would win if read
    return 16'(((a * 37) % 101) - 50);
  endfunction

  initial begin
    int bad, rd0, d0;
    int unsigned s_cyc;

    vecs[0] = '{16'd0, 16'd1, 16'd4, 16'd5, 16'd5};
    vecs[1] = '{16'd2, 16'd3, 16'd6, 16'd7, 16'd7};
    vecs[2] = '{16'd8, 16'd9, 16'd12, 16'd13, 16'd13};
    vecs[3] = '{16'd10, 16'd11, 16'd14, 16'd15, 16'd15};
    vecs[4] = '{16'hFFFD, 16'hFFF9, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    vecs[5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF};
    vecs[6] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vecs[7] = '{16'd5, 16'd9, 16'd9, 16'd2, 16'd9};
    for (int i = 0; i < 64; i++) mem_b[i] = b_val(i);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_rd_addr", a_rd_addr, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_idx", a_out_idx, 0);
    rst_n = 1'b1;

    // Table-driven runs: ramp map, then signed / extreme / tie windows.
    run_a(0, 1'b0);
    run_a(4, 1'b0);

    // Backpressure: out_ready low for 10 cycles in OUT.
    load_a(4);
    qa_data.delete();
    qa_idx.delete();
    a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (a_out_valid) break;
      @(posedge clk); #1;
    end
    chk("bp_valid", a_out_valid, 1);
    bad = 0;
    rd0 = a_rd_cnt;
    repeat (10) begin
      @(negedge clk);
      if (!a_out_valid || a_out_data !== 16'hFFFF || a_out_idx !== 2'd0) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_rd", a_rd_cnt - rd0, 0);
    chk("bp_data", a_out_data, 16'hFFFF);
    @(posedge clk); #1;
    d0 = a_done_cnt;
    a_out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (a_done_cnt != d0) break;
      @(posedge clk); #1;
    end
    chk("bp_done", a_done_cnt - d0, 1);
    compare_a(4);

    // Reset during FETCH of window 2.
    load_a(0);
    qa_data.delete();
    qa_idx.delete();
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (qa_data.size() == 2 && a_rd_en) break;
      @(posedge clk); #1;
    end
    chk("ab_reached_win2", qa_data.size(), 2);
    chk("ab_rd_en_before", a_rd_en, 1);
    d0 = a_done_cnt;
    #2 rst_n = 1'b0;
    #1;
    rd0 = a_rd_cnt;
    chk("ab_busy", a_busy, 0);
    chk("ab_done", a_done, 0);
    chk("ab_rd_en", a_rd_en, 0);
    chk("ab_rd_addr", a_rd_addr, 0);
    chk("ab_out_valid", a_out_valid, 0);
    chk("ab_out_data", a_out_data, 0);
    chk("ab_out_idx", a_out_idx, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("ab_no_done", a_done_cnt - d0, 0);
    chk("ab_no_rd", a_rd_cnt - rd0, 0);
    chk("ab_no_out", qa_data.size(), 2);
    run_a(0, 1'b0);

    // start pulsed while busy (FETCH, OUT, FETCH, DONE).
    run_a(0, 1'b1);

    // 5x6x2 map: 12 windows, row 4 never read, channel 1 at address 30.
    qb_data.delete();
    qb_idx.delete();
    qb_addr.delete();
    @(posedge clk); #1;
    d0 = b_done_cnt;
    b_start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (b_done_cnt != d0) break;
      @(posedge clk); #1;
    end
    chk("b_done_pulse", b_done_cnt - d0, 1);
    chk("b_latency", b_done_cyc - s_cyc, 73);
    chk("b_n_out", qb_data.size(), 12);
    chk("b_n_addr", qb_addr.size(), 48);
    bad = 0;
    foreach (qb_addr[i]) if (((qb_addr[i] % 30) / 6) == 4) bad++;
    chk("b_row4_reads", bad, 0);
    if (qb_addr.size() > 24) chk("b_ch1_first_addr", qb_addr[24], 30);
    for (int d = 0; d < 2; d++) begin
      for (int wr = 0; wr < 2; wr++) begin
        for (int wc = 0; wc < 3; wc++) begin
          int n, m, v, a;
          n = d * 6 + wr * 3 + wc;
          m = 0;
          for (int k = 0; k < 4; k++) begin
            a = d * 30 + (2 * wr + k / 2) * 6 + 2 * wc + k % 2;
            v = int'($signed(mem_b[a]));
            if (k == 0 || v > m) m = v;
            if (4 * n + k < qb_addr.size()) chk($sformatf("b_addr%0d", 4 * n + k),
                                                qb_addr[4 * n + k], a);
          end
          if (n < qb_data.size()) begin
            chk($sformatf("b_win%0d_data", n), qb_data[n], 16'(m));
            chk($sformatf("b_win%0d_idx", n), qb_idx[n], n);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
